// File: rtl/meas_pkg.sv
// Shared types and constants for the frequency-meter measurement sequencer.
//   opcode_e  : measurement selection, drives the counter mux through `mode`
//   state_e   : sequencer FSM states
//   HDR_BASE  : packet header base, low two bits carry the mode
//   pkt_len() : bytes per packet for a given result width
// Optional build macro: TX_CHECKSUM_EN appends one XOR checksum byte per packet.
package meas_pkg;

  typedef enum logic [1:0] {
    OP_FREQ   = 2'b00,
    OP_PERIOD = 2'b01,
    OP_DUTY   = 2'b10,
    OP_PHASE  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_WAIT,
    ST_SEND
  } state_e;

  localparam logic [7:0] HDR_BASE = 8'hA0;

`ifdef TX_CHECKSUM_EN
  localparam bit TX_CSUM = 1'b1;
`else
  localparam bit TX_CSUM = 1'b0;
`endif

  // header + result bytes + optional checksum
  function automatic int pkt_len(input int result_w);
    return 1 + result_w / 8 + (TX_CSUM ? 1 : 0);
  endfunction

  localparam int RESULT_W_DEFAULT = 32;
  localparam int PKT_LEN          = pkt_len(RESULT_W_DEFAULT);

endpackage

// File: rtl/meas_if.sv
// Byte stream from the sequencer to the UART transmitter.
//   tx_data  : byte to send
//   tx_valid : byte valid, held with tx_data until accepted
//   tx_ready : UART accepts when tx_valid & tx_ready
// master = byte source (sequencer), slave = UART side.
interface meas_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/meas_pkt_tx.sv
// Packet source for one measurement: header byte, result bytes MSB first and,
// when TX_CHECKSUM_EN is defined, a trailing XOR of all preceding bytes.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   load         : start a packet (one cycle), ignored while a packet is in flight
//                  only because the sequencer never pulses it then
//   mode         : measurement mode for the header byte
//   load_data    : result word to serialise
//   last_accept  : final byte is being accepted this cycle (combinational)
//   tx           : valid/ready byte stream, source side
module meas_pkt_tx
  import meas_pkg::*;
#(
  parameter int RESULT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [1:0]          mode,
  input  logic [RESULT_W-1:0] load_data,
  output logic                last_accept,
  meas_if.master              tx
);

  localparam int                PKT_BYTES = pkt_len(RESULT_W);
  localparam int                IDX_W     = $clog2(PKT_BYTES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PKT_BYTES - 1);

  logic [RESULT_W-1:0] shift_q;
  logic [IDX_W-1:0]    idx_q;
  logic [7:0]          data_q;
  logic                valid_q;
  logic [7:0]          next_byte;
  logic                xfer;

  assign xfer        = valid_q & tx.tx_ready;
  assign last_accept = xfer && (idx_q == IDX_LAST);
  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;

`ifdef TX_CHECKSUM_EN
  // csum_q holds the XOR of bytes already accepted; the byte on the bus is
  // folded in when the checksum byte itself is produced.
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 8'h00;
    end else if (load) begin
      csum_q <= 8'h00;
    end else if (xfer) begin
      csum_q <= csum_q ^ data_q;
    end
  end

  assign next_byte = (idx_q == IDX_W'(PKT_BYTES - 2)) ? (csum_q ^ data_q)
                                                      : shift_q[RESULT_W-1 -: 8];
`else
  assign next_byte = shift_q[RESULT_W-1 -: 8];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      shift_q <= '0;
      idx_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= HDR_BASE | {6'b0, mode};
      shift_q <= load_data;
      idx_q   <= '0;
    end else if (xfer) begin
      if (idx_q == IDX_LAST) begin
        valid_q <= 1'b0;
      end else begin
        idx_q   <= idx_q + IDX_W'(1);
        data_q  <= next_byte;
        shift_q <= shift_q << 8;
      end
    end
  end

endmodule

// File: rtl/meas_sequencer.sv
// Sequences one frequency-meter measurement: latches the opcode, clears and
// gates the counter datapath, waits for its result (or times out) and streams
// the framed packet to the UART. All outputs are registered.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   opcode      : requested measurement, latched into mode on accepted start
//   start       : request, sampled only in IDLE
//   ready       : high while IDLE
//   mode        : latched opcode, drives the counter mux
//   cnt_clr     : one-cycle clear pulse to the counter
//   gate_en     : counting window, GATE_CYCLES cycles
//   cnt_done    : counter result valid (level, already in clk domain)
//   cnt_result  : counter result, stable while cnt_done
//   tx          : byte stream to the UART (source side)
//   err         : last measurement timed out; cleared on next accepted start
// Optional build macro: TX_CHECKSUM_EN (trailing checksum byte, see meas_pkt_tx).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready=1, waiting for start
// ST_CLEAR | cnt_clr pulse for one cycle
// ST_GATE  | gate_en=1 for GATE_CYCLES cycles
// ST_WAIT  | waiting for cnt_done, abort after TIMEOUT_CYCLES
// ST_SEND  | streaming the packet, returns to IDLE on last byte accepted
module meas_sequencer
  import meas_pkg::*;
#(
  parameter int GATE_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int RESULT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          opcode,
  input  logic                start,
  output logic                ready,
  output logic [1:0]          mode,
  output logic                cnt_clr,
  output logic                gate_en,
  input  logic                cnt_done,
  input  logic [RESULT_W-1:0] cnt_result,
  meas_if.master              tx,
  output logic                err
);

  // One down-counter serves both the gate window and the wait timeout.
  localparam int               TMR_MAX  = (GATE_CYCLES > TIMEOUT_CYCLES) ? GATE_CYCLES
                                                                         : TIMEOUT_CYCLES;
  localparam int               TMR_W    = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] GATE_LD  = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LD   = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_nxt;
  logic [TMR_W-1:0]    tmr_q;
  opcode_e             mode_q;
  logic                ready_q, cnt_clr_q, gate_en_q, err_q;
  logic                accept, timeout, pkt_load, pkt_last;
  logic [RESULT_W-1:0] pkt_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    timeout   = 1'b0;
    pkt_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: state_nxt = ST_GATE;
      ST_GATE: begin
        if (tmr_q == '0) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // cnt_done takes priority over an expiring timer in the same cycle
        if (cnt_done) begin
          pkt_load  = 1'b1;
          state_nxt = ST_SEND;
        end else if (tmr_q == '0) begin
          timeout   = 1'b1;
          pkt_load  = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pkt_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b1;
      cnt_clr_q <= 1'b0;
      gate_en_q <= 1'b0;
      mode_q    <= OP_FREQ;
      err_q     <= 1'b0;
      tmr_q     <= '0;
    end else begin
      ready_q   <= (state_nxt == ST_IDLE);
      cnt_clr_q <= (state_nxt == ST_CLEAR);
      gate_en_q <= (state_nxt == ST_GATE);
      if (accept) begin
        mode_q <= opcode_e'(opcode);
        err_q  <= 1'b0;
      end else if (timeout) begin
        err_q  <= 1'b1;
      end
      if (state_q == ST_CLEAR) begin
        tmr_q <= GATE_LD;
      end else if (state_q == ST_GATE && tmr_q == '0) begin
        tmr_q <= TMO_LD;
      end else if (tmr_q != '0) begin
        tmr_q <= tmr_q - TMR_W'(1);
      end
    end
  end

  assign pkt_data = timeout ? {RESULT_W{1'b1}} : cnt_result;

  meas_pkt_tx #(
    .RESULT_W (RESULT_W)
  ) u_pkt_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (pkt_load),
    .mode        (mode_q),
    .load_data   (pkt_data),
    .last_accept (pkt_last),
    .tx          (tx)
  );

  assign ready   = ready_q;
  assign mode    = mode_q;
  assign cnt_clr = cnt_clr_q;
  assign gate_en = gate_en_q;
  assign err     = err_q;

endmodule

// File: tb/tb_meas_sequencer.sv
module tb_meas_sequencer;
  import meas_pkg::*;

  localparam int GATE = 10;
  localparam int TMO  = 20;
  localparam int RW   = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  opcode = 2'b00;
  logic        start = 1'b0;
  logic        ready, cnt_clr, gate_en, err;
  logic [1:0]  mode;
  logic        cnt_done = 1'b0;
  logic [31:0] cnt_result = 32'h0;
  logic        rdy_rand = 1'b0, rdy_man = 1'b0, rdy_rnd = 1'b0;

  meas_if tx_if();
  assign tx_if.tx_ready = rdy_rand ? rdy_rnd : rdy_man;

  meas_sequencer #(.GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TMO), .RESULT_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .start(start), .ready(ready),
    .mode(mode), .cnt_clr(cnt_clr), .gate_en(gate_en), .cnt_done(cnt_done),
    .cnt_result(cnt_result), .tx(tx_if), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rdy_rnd = 1'($urandom_range(0, 1));
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  int         clr_cnt = 0;
  int         gate_cnt = 0;
  logic [7:0] exp_q[$];
  bit         hold = 0;
  logic [7:0] hold_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expected byte on every accepted transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 0;
    end else begin
      if (hold) begin
        check("tx_hold_valid", 32'(tx_if.tx_valid), 32'd1);
        check("tx_hold_data", 32'(tx_if.tx_data), 32'(hold_data));
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_extra: got byte %0h expected none", tx_if.tx_data);
        end else begin
          check("tx_byte", 32'(tx_if.tx_data), 32'(exp_q.pop_front()));
        end
      end
      hold      = tx_if.tx_valid && !tx_if.tx_ready;
      hold_data = tx_if.tx_data;
      if (cnt_clr) clr_cnt++;
      if (gate_en) gate_cnt++;
    end
  end

  task automatic push_pkt(input logic [1:0] op, input logic [31:0] d);
    logic [7:0] b, cs;
    b = 8'hA0 | {6'b0, op};
    exp_q.push_back(b);
    cs = b;
    for (int i = 3; i >= 0; i--) begin
      b = d[i*8 +: 8];
      exp_q.push_back(b);
      cs = cs ^ b;
    end
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic pulse_start(input logic [1:0] op);
    @(posedge clk); #1;
    opcode = op;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // sel 0: ready, sel 1: tx_valid
  task automatic wait_for(input int sel, input logic lvl, input string name);
    int n;
    n = 0;
    while ((((sel == 0) ? ready : tx_if.tx_valid) !== lvl) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_wait: got no transition expected level %0b", name, lvl);
    end
  endtask

  task automatic measure(input string name, input logic [1:0] op, input int delay,
                         input bit no_done, input logic [31:0] res, input bit disturb);
    bit          tmo, seen;
    int          waits, exp_waits;
    logic [31:0] sent;
    tmo       = no_done || (delay >= TMO);
    exp_waits = tmo ? TMO : delay + 1;
    sent      = tmo ? 32'hFFFF_FFFF : res;
    cnt_result = res;
    clr_cnt   = 0;
    gate_cnt  = 0;
    push_pkt(op, sent);
    pulse_start(op);
    @(negedge clk);
    check({name, "_err_clr"}, 32'(err), 32'd0);
    check({name, "_busy"}, 32'(ready), 32'd0);
    if (disturb) begin
      @(posedge clk); #1;
      opcode = ~op;
      start  = 1'b1;
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gate_en) seen = 1;
      else if (seen) break;
    end
    waits = 0;
    fork
      begin
        if (!no_done) begin
          repeat (delay) @(posedge clk);
          #1 cnt_done = 1'b1;
        end
      end
      begin
        while (!tx_if.tx_valid && waits < 200) begin
          waits++;
          @(negedge clk);
        end
      end
    join
    wait_for(0, 1'b1, name);
    cnt_done = 1'b0;
    check({name, "_clr_pulses"}, 32'(clr_cnt), 32'd1);
    check({name, "_gate_cycles"}, 32'(gate_cnt), 32'(GATE));
    check({name, "_wait_cycles"}, 32'(waits), 32'(exp_waits));
    check({name, "_err"}, 32'(err), 32'(tmo));
    check({name, "_mode"}, 32'(mode), 32'(op));
    check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    check("rst_gate_en", 32'(gate_en), 32'd0);
    check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);

    rdy_man = 1'b1;
    measure("period", OP_PERIOD, 3, 1'b0, 32'h1234_5678, 1'b0);
    measure("timeout", OP_FREQ, 0, 1'b1, 32'h5555_AAAA, 1'b0);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);

    rdy_rand = 1'b1;
    measure("phase_rand", OP_PHASE, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    rdy_rand = 1'b0;
    measure("done_at_tmo", OP_DUTY, TMO - 1, 1'b0, 32'h00FF_00FF, 1'b0);
    measure("done_late", OP_PERIOD, TMO, 1'b0, 32'h1111_2222, 1'b0);
    rdy_rand = 1'b1;
    measure("disturb", OP_PERIOD, 5, 1'b0, 32'hCAFE_F00D, 1'b1);
    rdy_rand = 1'b0;

    // UART stalled: byte held, start during SEND ignored
    rdy_man    = 1'b0;
    clr_cnt    = 0;
    cnt_result = 32'h0BAD_F00D;
    cnt_done   = 1'b1;
    push_pkt(OP_DUTY, 32'h0BAD_F00D);
    pulse_start(OP_DUTY);
    wait_for(1, 1'b1, "stall_valid");
    repeat (5) @(posedge clk);
    #1 start = 1'b1; opcode = OP_PHASE;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("stall_valid", 32'(tx_if.tx_valid), 32'd1);
    check("stall_data", 32'(tx_if.tx_data), 32'hA2);
    check("stall_ready", 32'(ready), 32'd0);
    check("stall_mode", 32'(mode), 32'(OP_DUTY));
    rdy_man = 1'b1;
    wait_for(0, 1'b1, "stall_done");
    cnt_done = 1'b0;
    check("stall_clr_pulses", 32'(clr_cnt), 32'd1);
    check("stall_bytes_left", 32'(exp_q.size()), 32'd0);

    // Back-to-back with start held high
    clr_cnt    = 0;
    cnt_result = 32'h0102_0304;
    cnt_done   = 1'b1;
    push_pkt(OP_FREQ, 32'h0102_0304);
    push_pkt(OP_FREQ, 32'h0102_0304);
    @(posedge clk); #1;
    opcode = OP_FREQ;
    start  = 1'b1;
    wait_for(0, 1'b0, "b2b_start");
    wait_for(0, 1'b1, "b2b_first");
    @(negedge clk);
    check("b2b_restart_ready", 32'(ready), 32'd0);
    check("b2b_restart_clr", 32'(cnt_clr), 32'd1);
    start = 1'b0;
    wait_for(0, 1'b1, "b2b_second");
    cnt_done = 1'b0;
    check("b2b_clr_pulses", 32'(clr_cnt), 32'd2);
    check("b2b_bytes_left", 32'(exp_q.size()), 32'd0);

    // Reset during SEND byte 2
    rdy_man    = 1'b0;
    cnt_result = 32'hA5A5_1234;
    cnt_done   = 1'b1;
    push_pkt(OP_DUTY, 32'hA5A5_1234);
    pulse_start(OP_DUTY);
    wait_for(1, 1'b1, "rst_mid_valid");
    @(posedge clk); #1 rdy_man = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rdy_man = 1'b0;
    @(negedge clk);
    check("rst_mid_byte2", 32'(tx_if.tx_data), 32'hA5);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check("rst_mid_tx_data", 32'(tx_if.tx_data), 32'd0);
    check("rst_mid_mode", 32'(mode), 32'd0);
    check("rst_mid_gate", 32'(gate_en), 32'd0);
    exp_q.delete();
    cnt_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_man = 1'b1;
    measure("after_rst", OP_PHASE, 2, 1'b0, 32'h8765_4321, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
